// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants, FSM state type and stall-bus helpers for the pipeline stall controller.
package hazard_stall_ctrl_pkg;

    localparam int unsigned DEPTH_W = 3;
    localparam int unsigned MASK_W  = 8;

    // Stage indices; a bubble entering stage k means stages 0..k-1 are frozen
    localparam int unsigned STAGE_ID  = 2;
    localparam int unsigned STAGE_EX  = 3;
    localparam int unsigned STAGE_MEM = 4;
    localparam int unsigned STAGE_WB  = 5;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [DEPTH_W-1:0] DEPTH_NONE     = DEPTH_W'(0);
    localparam logic [DEPTH_W-1:0] DEPTH_IFETCH   = DEPTH_W'(STAGE_ID);
    localparam logic [DEPTH_W-1:0] DEPTH_LOAD_USE = DEPTH_W'(STAGE_EX);
    localparam logic [DEPTH_W-1:0] DEPTH_MULDIV   = DEPTH_W'(STAGE_MEM);
    localparam logic [DEPTH_W-1:0] DEPTH_DMEM     = DEPTH_W'(STAGE_WB);

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Stall request from each cause, grouped for the priority encoder
    typedef struct packed {
        logic dmem_wait;
        logic muldiv;
        logic load_use;
        logic ifetch_wait;
    } stall_cause_t;

    // Prefix of ones: the lowest `depth` stages stopped, the rest free-running
    function automatic logic [MASK_W-1:0] prefix_mask(input logic [DEPTH_W-1:0] depth);
        logic [MASK_W-1:0] mask;
        mask = '0;
        for (int k = 0; k < MASK_W; k++) begin
            mask[k] = (k < int'(depth)) ? STOP : NO_STOP;
        end
        return mask;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_muldiv_seq.sv
// Mul/div sequencer: IDLE/BUSY/DONE FSM with busy-cycle down-counter.
module muldiv_seq
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned CNT_W      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start,
    input  logic md_is_div,
    input  logic data_sram_wait,
    output logic md_busy,
    output logic md_done,
    output logic md_stall_req
);

    md_state_e        state;
    md_state_e        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             busy_next;
    logic             done_next;

    // State, counter and registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= MD_IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
            md_done <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            md_busy <= busy_next;
            md_done <= done_next;
        end
    end

    // Next state; the operation only launches once the MEM stage is not waiting
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        md_stall_req = 1'b0;
        busy_next    = 1'b0;
        done_next    = 1'b0;
        case (state)
            MD_IDLE: begin
                md_stall_req = md_start;
                if (md_start && !data_sram_wait) begin
                    state_next = MD_BUSY;
                    cnt_next   = md_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
                end
            end
            MD_BUSY: begin
                md_stall_req = 1'b1;
                if (cnt == '0) begin
                    state_next = MD_DONE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            MD_DONE: begin
                // md_start ignored here so the instruction still in EX cannot relaunch
                if (!data_sram_wait) begin
                    state_next = MD_IDLE;
                end
            end
            default: begin
                state_next = MD_IDLE;
                cnt_next   = '0;
            end
        endcase
        busy_next = (state_next == MD_BUSY);
        done_next = (state_next == MD_DONE);
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall controller: load-use detect, cause priority, prefix stall bus.
// Optional HAZ_PERF_EN adds saturating load-use / mul-div stall-cycle counters.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned STALL_W    = 6,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 33,
    parameter int unsigned CNT_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    input  logic               ex_is_load,
    input  logic               ex_rf_we,
    input  logic [4:0]         ex_rf_waddr,
    input  logic               md_start,
    input  logic               md_is_div,
    input  logic               inst_sram_wait,
    input  logic               data_sram_wait,
    output logic [STALL_W-1:0] stall,
    output logic               md_busy,
    output logic               md_done,
    output logic [31:0]        lu_stall_cnt,
    output logic [31:0]        md_stall_cnt
);

    stall_cause_t       cause;
    logic               load_use;
    logic               md_stall_req;
    logic [DEPTH_W-1:0] depth;

    muldiv_seq #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_muldiv_seq (
        .clk            (clk),
        .rst            (rst),
        .md_start       (md_start),
        .md_is_div      (md_is_div),
        .data_sram_wait (data_sram_wait),
        .md_busy        (md_busy),
        .md_done        (md_done),
        .md_stall_req   (md_stall_req)
    );

    // Load in EX feeding a register read in ID; r0 never creates a dependency
    always_comb begin
        load_use = ex_is_load && ex_rf_we && (ex_rf_waddr != 5'd0) &&
                   ((id_use_rs && (id_rs == ex_rf_waddr)) ||
                    (id_use_rt && (id_rt == ex_rf_waddr)));
    end

    // Deepest requested bubble wins
    always_comb begin
        cause             = '0;
        cause.dmem_wait   = data_sram_wait;
        cause.muldiv      = md_stall_req;
        cause.load_use    = load_use;
        cause.ifetch_wait = inst_sram_wait;
        depth             = DEPTH_NONE;
        if (cause.dmem_wait) begin
            depth = DEPTH_DMEM;
        end else if (cause.muldiv) begin
            depth = DEPTH_MULDIV;
        end else if (cause.load_use) begin
            depth = DEPTH_LOAD_USE;
        end else if (cause.ifetch_wait) begin
            depth = DEPTH_IFETCH;
        end
    end

    assign stall = STALL_W'(prefix_mask(depth));

`ifdef HAZ_PERF_EN
    logic [31:0] lu_cnt;
    logic [31:0] md_cnt;
    logic        lu_cause;

    // Load-use only counts when it alone sets the bubble depth
    assign lu_cause = (depth == DEPTH_LOAD_USE);

    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt <= '0;
            md_cnt <= '0;
        end else begin
            if (lu_cause && (lu_cnt != 32'hFFFF_FFFF)) begin
                lu_cnt <= lu_cnt + 32'd1;
            end
            if (md_stall_req && (md_cnt != 32'hFFFF_FFFF)) begin
                md_cnt <= md_cnt + 32'd1;
            end
        end
    end

    assign lu_stall_cnt = lu_cnt;
    assign md_stall_cnt = md_cnt;
`else
    assign lu_stall_cnt = 32'b0;
    assign md_stall_cnt = 32'b0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: vector table, corner sequences, random vs. model.
module tb_hazard_stall_ctrl;

`ifdef HAZ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int MUL_N = 4;
    localparam int DIV_N = 33;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rf_waddr;
    logic       id_use_rs, id_use_rt, ex_is_load, ex_rf_we;
    logic       md_start, md_is_div, inst_sram_wait, data_sram_wait;
    logic [5:0] stall;
    logic       md_busy, md_done;
    logic [31:0] lu_stall_cnt, md_stall_cnt;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_use_rs      (id_use_rs),
        .id_use_rt      (id_use_rt),
        .ex_is_load     (ex_is_load),
        .ex_rf_we       (ex_rf_we),
        .ex_rf_waddr    (ex_rf_waddr),
        .md_start       (md_start),
        .md_is_div      (md_is_div),
        .inst_sram_wait (inst_sram_wait),
        .data_sram_wait (data_sram_wait),
        .stall          (stall),
        .md_busy        (md_busy),
        .md_done        (md_done),
        .lu_stall_cnt   (lu_stall_cnt),
        .md_stall_cnt   (md_stall_cnt)
    );

    typedef struct {
        string      name;
        logic [4:0] rs, rt, waddr;
        logic       use_rs, use_rt, is_load, we, ms, iw, dw;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic ld, input logic we,
                                input logic [4:0] wa, input logic ms, input logic iw,
                                input logic dw, input logic [5:0] exp);
        vec_t v;
        v.name = n; v.rs = rs; v.rt = rt; v.use_rs = urs; v.use_rt = urt;
        v.is_load = ld; v.we = we; v.waddr = wa; v.ms = ms; v.iw = iw; v.dw = dw; v.exp = exp;
        return v;
    endfunction

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_is_load = 1'b0; ex_rf_we = 1'b0; ex_rf_waddr = '0;
        md_start = 1'b0; md_is_div = 1'b0; inst_sram_wait = 1'b0; data_sram_wait = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_load_use();
        ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_rf_waddr = 5'd5;
        id_rs = 5'd5; id_use_rs = 1'b1;
    endtask

    // Reference model: remaining busy cycles plus a done flag, stall from cause depths
    int          m_left;
    bit          m_done;
    int unsigned m_lu, m_md;

    initial begin
        int   stall_cycles, done_cyc;
        bit   saw_done;
        rst = 1'b1;
        idle_inputs();

        vecs.push_back(mk("v_idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
        vecs.push_back(mk("v_lu_rs",      5, 0, 1, 0, 1, 1, 5, 0, 0, 0, 6'b000111));
        vecs.push_back(mk("v_lu_r0",      0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 6'b000000));
        vecs.push_back(mk("v_lu_rt",      1, 9, 1, 1, 1, 1, 9, 0, 0, 0, 6'b000111));
        vecs.push_back(mk("v_lu_no_use",  7, 7, 0, 0, 1, 1, 7, 0, 0, 0, 6'b000000));
        vecs.push_back(mk("v_not_load",   7, 0, 1, 0, 0, 1, 7, 0, 0, 0, 6'b000000));
        vecs.push_back(mk("v_no_we",      7, 0, 1, 0, 1, 0, 7, 0, 0, 0, 6'b000000));
        vecs.push_back(mk("v_addr_diff",  6, 8, 1, 1, 1, 1, 7, 0, 0, 0, 6'b000000));
        vecs.push_back(mk("v_iwait",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b000011));
        vecs.push_back(mk("v_dwait",      0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b011111));
        vecs.push_back(mk("v_md_start",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6'b001111));
        vecs.push_back(mk("v_prio3",      5, 0, 1, 0, 1, 1, 5, 1, 1, 0, 6'b001111));
        vecs.push_back(mk("v_prio4",      5, 0, 1, 0, 1, 1, 5, 1, 1, 1, 6'b011111));
        vecs.push_back(mk("v_lu_iw",      5, 0, 1, 0, 1, 1, 5, 0, 1, 0, 6'b000111));

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_busy", 32'(md_busy), 32'd0);
        check("rst_done", 32'(md_done), 32'd0);
        check("rst_lu_cnt", lu_stall_cnt, 32'd0);
        check("rst_md_cnt", md_stall_cnt, 32'd0);
        rst = 1'b0;

        // Combinational vector table, each from a fresh IDLE state
        foreach (vecs[i]) begin
            do_reset();
            @(negedge clk);
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_use_rs = vecs[i].use_rs;
            id_use_rt = vecs[i].use_rt; ex_is_load = vecs[i].is_load; ex_rf_we = vecs[i].we;
            ex_rf_waddr = vecs[i].waddr; md_start = vecs[i].ms; md_is_div = 1'b0;
            inst_sram_wait = vecs[i].iw; data_sram_wait = vecs[i].dw;
            #1;
            check(vecs[i].name, 32'(stall), 32'(vecs[i].exp));
        end

        // Load-use clears once the load moves on and EX holds the bubble
        do_reset();
        @(negedge clk); drive_load_use(); #1;
        check("lu_seq_c1", 32'(stall), 32'b000111);
        @(negedge clk); ex_is_load = 1'b0; ex_rf_we = 1'b0; ex_rf_waddr = '0; #1;
        check("lu_seq_c2", 32'(stall), 32'd0);

        // Divide: 34 stall cycles, done on cycle 35, start ignored in DONE
        do_reset();
        stall_cycles = 0; done_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            md_start = (c <= 35); md_is_div = 1'b1;
            #1;
            if (stall == 6'b001111) stall_cycles++;
            if (md_done && done_cyc == 0) done_cyc = c;
            if (c == 10) check("div_busy", 32'(md_busy), 32'd1);
            if (c == 35) check("div_done_nostall", 32'(stall), 32'd0);
            if (c == 36) check("div_idle", 32'({md_busy, md_done}), 32'd0);
        end
        check("div_stall_cycles", 32'(stall_cycles), 32'(DIV_N + 1));
        check("div_done_cycle", 32'(done_cyc), 32'(DIV_N + 2));

        // Multiply with data wait arriving in DONE
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            md_start = (c <= 9); md_is_div = 1'b0;
            data_sram_wait = (c >= 6 && c <= 8);
            #1;
            if (c == 1) check("mul_c1_stall", 32'(stall), 32'b001111);
            if (c == 5) check("mul_c5_stall", 32'(stall), 32'b001111);
            if (c == 6) check("mul_c6_done", 32'(md_done), 32'd1);
            if (c == 6) check("mul_c6_stall", 32'(stall), 32'b011111);
            if (c == 8) check("mul_c8_done", 32'(md_done), 32'd1);
            if (c == 9) check("mul_c9_done", 32'(md_done), 32'd1);
            if (c == 9) check("mul_c9_stall", 32'(stall), 32'd0);
            if (c == 10) check("mul_c10_idle", 32'({md_busy, md_done}), 32'd0);
        end

        // Reset in cycle 10 of BUSY aborts without done
        do_reset();
        saw_done = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            md_start = (c <= 11); md_is_div = 1'b1; rst = (c == 11);
            #1;
            if (c == 11) check("rdiv_busy", 32'(md_busy), 32'd1);
            if (c == 12) check("rdiv_stall", 32'(stall), 32'd0);
            if (c == 12) check("rdiv_nobusy", 32'(md_busy), 32'd0);
            if (c >= 12 && md_done) saw_done = 1'b1;
        end
        rst = 1'b0;
        check("rdiv_no_done", 32'(saw_done), 32'd0);

        // Perf: one load-use cycle plus one multiply
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            idle_inputs();
            if (c == 1) drive_load_use();
            md_start = (c >= 3 && c <= 8);
            #1;
        end
        check("perf_lu", lu_stall_cnt, PERF ? 32'd1 : 32'd0);
        check("perf_md", md_stall_cnt, PERF ? 32'(MUL_N + 1) : 32'd0);

        // Randomized run against the reference model
        do_reset();
        m_left = 0; m_done = 1'b0; m_lu = 0; m_md = 0;
        for (int i = 0; i < 3000; i++) begin
            bit         idle_m, md_req, lu;
            int         depth;
            logic [5:0] exp_stall;
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            ex_rf_waddr = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            ex_is_load = ($urandom_range(0, 2) == 0); ex_rf_we = ($urandom_range(0, 3) != 0);
            inst_sram_wait = ($urandom_range(0, 3) == 0);
            data_sram_wait = ($urandom_range(0, 4) == 0);
            if (md_start) begin
                md_start = ($urandom_range(0, 7) != 0);
            end else begin
                md_start = ($urandom_range(0, 5) == 0);
                if (md_start) md_is_div = ($urandom_range(0, 3) == 0);
            end
            #1;
            idle_m = (m_left == 0) && !m_done;
            md_req = (idle_m && md_start) || (m_left > 0);
            lu = ex_is_load && ex_rf_we && ex_rf_waddr != 0 &&
                 ((id_use_rs && id_rs == ex_rf_waddr) || (id_use_rt && id_rt == ex_rf_waddr));
            depth = 0;
            if (inst_sram_wait) depth = 2;
            if (lu && depth < 3) depth = 3;
            if (md_req && depth < 4) depth = 4;
            if (data_sram_wait) depth = 5;
            exp_stall = '0;
            for (int k = 0; k < depth; k++) exp_stall[k] = 1'b1;
            check("rnd_stall", 32'(stall), 32'(exp_stall));
            check("rnd_busy", 32'(md_busy), 32'(m_left > 0));
            check("rnd_done", 32'(md_done), 32'(m_done));
            check("rnd_lu_cnt", lu_stall_cnt, m_lu);
            check("rnd_md_cnt", md_stall_cnt, m_md);
            if (rst) begin
                m_left = 0; m_done = 1'b0; m_lu = 0; m_md = 0;
            end else begin
                if (PERF && lu && depth == 3 && m_lu != 32'hFFFF_FFFF) m_lu++;
                if (PERF && md_req && m_md != 32'hFFFF_FFFF) m_md++;
                if (m_done) begin
                    if (!data_sram_wait) m_done = 1'b0;
                end else if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) m_done = 1'b1;
                end else if (md_start && !data_sram_wait) begin
                    m_left = md_is_div ? DIV_N : MUL_N;
                end
            end
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central pipeline controller for the 5-stage MIPS core. Collects stall causes (ID load-use hazard, EX multi-cycle mul/div, instruction/data SRAM wait) and drives the shared stall bus consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Sequences the multi-cycle mul/div unit with an FSM and counter, and signals when its result is valid.

Parameters:
STALL_W, 6, stall bus width, one bit per stage (0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB)
MUL_CYCLES, 4, mul/div unit busy cycles for a multiply
DIV_CYCLES, 33, mul/div unit busy cycles for a divide
CNT_W, 6, counter width; must hold max(MUL_CYCLES, DIV_CYCLES)-1

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
id_rs  in  5  ID-stage rs address
id_rt  in  5  ID-stage rt address
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
ex_is_load  in  1  EX instruction is a load
ex_rf_we  in  1  EX instruction writes the regfile
ex_rf_waddr  in  5  EX destination register
md_start  in  1  EX holds a mul/div instruction (level)
md_is_div  in  1  1 = divide, 0 = multiply; valid with md_start
inst_sram_wait  in  1  instruction fetch not yet returned
data_sram_wait  in  1  MEM-stage data access not yet returned
stall  out  STALL_W  stall bus; bit k = 1 (Stop) freezes stage k
md_busy  out  1  mul/div unit is computing
md_done  out  1  mul/div result valid; EX captures it this cycle
lu_stall_cnt  out  32  load-use stall cycles (see Optional Feature)
md_stall_cnt  out  32  mul/div stall cycles (see Optional Feature)

Behaviour:
- Reset: stall=0, md_busy=0, md_done=0, FSM=IDLE, counter=0, perf counters=0. A reset during BUSY or DONE aborts the operation with no done pulse.
- Stall bus is always a prefix of ones: stall = {(STALL_W-n){0}, {n{1}}}. A bubble enters stage n, where n is the number of asserted bits.
- n is the maximum over all active causes:
  - data_sram_wait → n=5
  - mul/div stall → n=4
  - load-use hazard → n=3
  - inst_sram_wait → n=2
- Load-use hazard (combinational) = ex_is_load & ex_rf_we & ex_rf_waddr!=0 & ((id_use_rs & id_rs==ex_rf_waddr) | (id_use_rt & id_rt==ex_rf_waddr)).
  - Lasts exactly one cycle: the load advances to MEM and the bubble clears the match. Forwarding then supplies the data.
- Mul/div FSM states are IDLE, BUSY and DONE.
  - IDLE: if md_start and !data_sram_wait, load counter with (md_is_div ? DIV_CYCLES : MUL_CYCLES)-1, go to BUSY. If data_sram_wait is high, stay in IDLE.
  - BUSY: md_busy=1. Counter decrements each cycle, including cycles where data_sram_wait is high. When counter==0, go to DONE.
  - DONE: md_done=1, no mul/div stall. Go to IDLE when !data_sram_wait; otherwise hold DONE with md_done high.
  - In DONE, md_start is ignored, so the mul/div instruction still in EX does not retrigger.
- Mul/div stall = (IDLE & md_start) | BUSY.
  - Total stall = 1 + N cycles, where N is MUL_CYCLES or DIV_CYCLES.
  - md_done rises on cycle N+2 after md_start is first seen.
- md_start deasserted in BUSY (not legal in normal flow): the FSM completes anyway and pulses md_done.
- All outputs except stall are registered. stall is combinational from the inputs plus FSM state.

Optional Feature:
HAZ_PERF_EN
- Defined: lu_stall_cnt increments on each cycle where the load-use hazard is the cause setting n. md_stall_cnt increments on each cycle the mul/div stall is high. Both saturate at 32'hFFFF_FFFF and clear on reset.
- Not defined: both ports are tied to 32'b0 and no counter flops exist.

Decomposition:
- lib/defines.vh holds StallBus, Stop/NoStop, stage index constants and the FSM state encodings.
- One sub-module, muldiv_seq: FSM plus counter, with outputs md_busy, md_done and md_stall_req.
- The top level does hazard compare, priority/prefix encoding and the perf counters.

Test Plan:
- Load-use: ex_is_load=1, ex_rf_we=1, ex_rf_waddr=5, id_rs=5, id_use_rs=1 → stall=6'b000111 for exactly 1 cycle. With ex_rf_waddr=0 → stall=0.
- Divide: md_start=1, md_is_div=1 with default params → stall=6'b001111 for 34 cycles, md_done=1 on cycle 35, md_start then ignored, FSM returns to IDLE.
- Multiply with data_sram_wait=1 arriving during DONE → stall=6'b011111, md_done held high until the wait drops, then IDLE.
- Priority: inst_sram_wait, load-use and md_start asserted together → stall=6'b001111. Adding data_sram_wait → 6'b011111.
- Reset mid-divide (cycle 10 of BUSY) → next cycle stall=0, md_busy=0, no md_done pulse.
- HAZ_PERF_EN: one load-use plus one multiply → lu_stall_cnt=1, md_stall_cnt=5. Without the macro both read 0.
